// File: rtl/delay_forward_ctrl.sv
// Issue-stage producer control for the delayed-execution path: shadows in-flight
// destination registers through EXE/SBA/REEXE and picks a forward source per operand.

module df_src_dec #(
  parameter int STAGES = 3
) (
  input  logic                   is_reg,
  input  logic [4:0]             src,
  input  logic [STAGES:1]        e_vld,
  input  logic [STAGES:1][4:0]   e_wnum,
  input  logic [STAGES:1]        e_late,
  output logic [2:0]             sel,
  output logic                   need_delay,
  output logic                   stall
);
  localparam int DW = $clog2(STAGES + 1);
  logic [DW-1:0] d;

  always_comb begin
    d = '0;
    // walk oldest to youngest so the youngest matching writer wins
    for (int k = STAGES; k >= 1; k--)
      if (is_reg && src != 5'd0 && e_vld[k] && e_wnum[k] == src) d = k[DW-1:0];
    sel        = 3'b001;
    need_delay = 1'b0;
    stall      = 1'b0;
    if (d == DW'(1)) begin
      if (e_late[1]) stall = 1'b1;
      else begin
        sel        = 3'b010;
        need_delay = 1'b1;
      end
    end else if (d == DW'(2)) begin
      sel        = 3'b100;
      need_delay = 1'b1;
    end
  end
endmodule

module delay_forward_ctrl #(
  parameter int STAGES = 3,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_w_i,
  input  logic             ID_valid_w_i,
  input  logic             ID_delayable_w_i,
  input  logic [4:0]       ID_writeNum_w_i,
  input  logic             ID_resultLate_w_i,
  input  logic [4:0]       ID_src0Num_w_i,
  input  logic [4:0]       ID_src1Num_w_i,
  input  logic             ID_src0IsReg_w_i,
  input  logic             ID_src1IsReg_w_i,
  input  logic             EXE_allowin_w_i,
  input  logic             SBA_allowin_w_i,
  input  logic             MEM_allowin_w_i,
  output logic             ID_okToIssue_w_o,
  output logic [2:0]       ID_forwardSel0_o,
  output logic [2:0]       ID_forwardSel1_o,
  output logic             ID_oprand0IsReg_o,
  output logic             ID_oprand1IsReg_o,
  output logic             ID_notExc_o,
  output logic [CNT_W-1:0] stallCnt_o
);
  typedef struct packed {
    logic       vld;
    logic [4:0] wnum;
    logic       late;
  } ent_t;

  ent_t                 ent [1:STAGES];
  ent_t                 new_ent;
  logic [STAGES:1]      allow;
  logic [STAGES:1]      e_vld, e_late;
  logic [STAGES:1][4:0] e_wnum;

  logic [1:0]           is_reg_v, need_v, stall_v;
  logic [1:0][4:0]      src_v;
  logic [1:0][2:0]      sel_v;
  logic                 need_any, stall;

  assign new_ent = '{vld: ID_valid_w_i & ID_okToIssue_w_o,
                     wnum: ID_writeNum_w_i, late: ID_resultLate_w_i};

  for (genvar k = 1; k <= STAGES; k++) begin : g_stage
    ent_t up;
    logic bubble;
    assign allow[k]  = (k == 1) ? EXE_allowin_w_i :
                       (k == STAGES) ? MEM_allowin_w_i : SBA_allowin_w_i;
    assign e_vld[k]  = ent[k].vld;
    assign e_wnum[k] = ent[k].wnum;
    assign e_late[k] = ent[k].late;
    if (k == 1) begin : g_head
      assign up = new_ent;
    end else begin : g_body
      assign up = ent[k-1];
    end
    // downstream pulling while this stage holds would duplicate the entry
    if (k < STAGES) begin : g_bub
      assign bubble = allow[k+1];
    end else begin : g_nobub
      assign bubble = 1'b0;
    end
    always_ff @(posedge clk) begin
      if (!rst || flush_w_i) ent[k] <= '0;
      else if (allow[k])     ent[k] <= up;
      else if (bubble)       ent[k] <= '0;
    end
  end

  assign is_reg_v = {ID_src1IsReg_w_i, ID_src0IsReg_w_i};
  assign src_v    = {ID_src1Num_w_i, ID_src0Num_w_i};

  for (genvar s = 0; s < 2; s++) begin : g_src
    df_src_dec #(.STAGES(STAGES)) u_dec (
      .is_reg     (is_reg_v[s]),
      .src        (src_v[s]),
      .e_vld      (e_vld),
      .e_wnum     (e_wnum),
      .e_late     (e_late),
      .sel        (sel_v[s]),
      .need_delay (need_v[s]),
      .stall      (stall_v[s])
    );
  end

  assign need_any          = |need_v;
  assign stall             = (|stall_v) | (need_any & ~ID_delayable_w_i);
  assign ID_okToIssue_w_o  = ~(ID_valid_w_i & stall);
  assign ID_forwardSel0_o  = stall ? 3'b001 : sel_v[0];
  assign ID_forwardSel1_o  = stall ? 3'b001 : sel_v[1];
  assign ID_notExc_o       = ID_valid_w_i & need_any & ID_delayable_w_i & ~stall;
  assign ID_oprand0IsReg_o = ID_src0IsReg_w_i;
  assign ID_oprand1IsReg_o = ID_src1IsReg_w_i;

  always_ff @(posedge clk) begin
    if (!rst)
      stallCnt_o <= '0;
    else if (ID_valid_w_i && stall && stallCnt_o != '1)
      stallCnt_o <= stallCnt_o + 1'b1;
  end
endmodule
